// File: rtl/spi_final.sv
// spi_final: byte-wide, write-only SPI master transmitter (mode 0, MSB first).
// A 0->1 transition on data_av while idle launches one frame of data_in onto
// spi_mosi_out. The generated serial clock idles low and chip select is active
// low. Every output comes straight from a flop, so there are no combinational
// paths from inputs to outputs.
//
// Request semantics: data_av is a fire-and-forget strobe with no ready or
// acknowledge. Only its rising edge counts, and only while the FSM is in IDLE.
// An edge seen while a frame is in flight is consumed and dropped, not queued.
// busy is high from the cycle after launch until the FSM returns to IDLE.
// data_in is sampled only on the launching clock edge.
module spi_final #(
  parameter int DATA_W   = 8,
  parameter int HALF_DIV = 1
) (
  output logic              spi_mosi_out,
  input  logic              m_clk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_av,
  output logic              spi_sclk_out,
  output logic              spi_cs_n_out,
  output logic              busy
);

  // One bit time is a low half and a high half of the serial clock.
  localparam int BIT_CYC = 2 * HALF_DIV;
  localparam int DIV_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYC - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Frame sequencer. The current state is visible to checkers as 'state'.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  div;
  logic              data_av_q;

  logic              av_s;
  logic              launch;
  logic [DIV_W-1:0]  div_next;

  // An unknown strobe must never start a frame, so anything but a clean 1 is 0.
  assign av_s     = (data_av === 1'b1);
  assign launch   = av_s & ~data_av_q & (state == IDLE);
  assign div_next = div + DIV_ONE;

  // Edge detector, frame sequencer and registered SPI outputs.
  // The output flops are loaded with the value the lines must show in the
  // cycle after each edge, so cs_n and the first MOSI bit appear one cycle
  // after the edge that detects the data_av rise.
  always_ff @(posedge m_clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      div          <= '0;
      data_av_q    <= 1'b0;
      spi_mosi_out <= 1'b0;
      spi_sclk_out <= 1'b0;
      spi_cs_n_out <= 1'b1;
      busy         <= 1'b0;
    end else begin
      // Tracks in every state so an edge arriving while busy is consumed.
      data_av_q <= av_s;

      case (state)
        IDLE: begin
          if (launch) begin
            state        <= SHIFT;
            shift_reg    <= data_in;
            bit_cnt      <= CNT_TOP;
            div          <= '0;
            spi_mosi_out <= data_in[DATA_W-1];
            spi_sclk_out <= 1'b0;
            spi_cs_n_out <= 1'b0;
            busy         <= 1'b1;
          end
        end

        SHIFT: begin
          if (div == DIV_LAST) begin
            // End of a bit time: sclk falls, and MOSI only moves here.
            spi_sclk_out <= 1'b0;
            div          <= '0;
            if (bit_cnt == '0) begin
              state        <= DONE;
              spi_cs_n_out <= 1'b1;
              spi_mosi_out <= 1'b0;
            end else begin
              shift_reg    <= shift_reg << 1;
              bit_cnt      <= bit_cnt - CNT_ONE;
              spi_mosi_out <= shift_reg[DATA_W-2];
            end
          end else begin
            // Inside a bit time: sclk is high for the second half.
            div          <= div_next;
            spi_sclk_out <= (div_next >= DIV_HALF);
          end
        end

        DONE: begin
          // One cycle of cs_n high with busy still set, so frames never abut.
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          spi_mosi_out <= 1'b0;
          spi_sclk_out <= 1'b0;
          spi_cs_n_out <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_final.sv
// tb_spi_final: randomized and directed stimulus for spi_final. The driver
// keeps a frame-level reference model: an accepted data_av edge queues the byte
// and the cycle in which cs_n must fall. A separate monitor decodes the SPI
// lines into frames and checks them against the queue.
module tb_spi_final;

  localparam int DATA_W    = 8;
  localparam int HALF_DIV  = 1;
  localparam int FRAME_LOW = DATA_W * 2 * HALF_DIV;

  logic              m_clk   = 1'b0;
  logic              n_reset = 1'b0;
  logic              data_av = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              spi_mosi_out;
  logic              spi_sclk_out;
  logic              spi_cs_n_out;
  logic              busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Scoreboard: expected bytes and the cycle in which each frame must start.
  logic [DATA_W-1:0] exp_q[$];
  int                exp_t_q[$];

  // Reference model state: last data_av level seen and first cycle a new
  // edge can be accepted again.
  logic m_prev_av = 1'b0;
  int   m_free_at = 0;

  spi_final #(.DATA_W(DATA_W), .HALF_DIV(HALF_DIV)) dut (
    .spi_mosi_out (spi_mosi_out),
    .m_clk        (m_clk),
    .n_reset      (n_reset),
    .data_in      (data_in),
    .data_av      (data_av),
    .spi_sclk_out (spi_sclk_out),
    .spi_cs_n_out (spi_cs_n_out),
    .busy         (busy)
  );

  // Clock and cycle index. After posedge j, cyc == j.
  always #5 m_clk = ~m_clk;
  always @(posedge m_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model of one sampling edge (index cyc+1) with the current data_av/data_in.
  // Each frame keeps the master occupied for FRAME_LOW cycles of cs_n low,
  // one trailing cycle and the return to idle.
  task automatic model_sample();
    int k;
    k = cyc + 1;
    if (data_av && !m_prev_av && k >= m_free_at) begin
      exp_q.push_back(data_in);
      exp_t_q.push_back(k);
      m_free_at = k + FRAME_LOW + 2;
    end
    m_prev_av = data_av;
  endtask

  task automatic step(input logic av, input logic [DATA_W-1:0] din);
    @(posedge m_clk);
    #1;
    data_av = av;
    data_in = din;
    if (n_reset) model_sample();
    else m_prev_av = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, DATA_W'($urandom));
  endtask

  task automatic reset_assert();
    @(posedge m_clk);
    #1;
    n_reset = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    m_prev_av = 1'b0;
    m_free_at = 0;
    #1;
    check("async_reset_lines", {spi_mosi_out, spi_sclk_out, spi_cs_n_out, busy}, 4'b0010);
  endtask

  task automatic reset_release();
    @(posedge m_clk);
    #1;
    n_reset = 1'b1;
    model_sample();
  endtask

  // Monitor: decodes frames on the SPI lines and checks them.
  logic              in_frame    = 1'b0;
  logic              prev_sclk   = 1'b0;
  logic              rise_mosi   = 1'b0;
  logic              mosi_stable = 1'b1;
  int                nbits       = 0;
  int                low_cnt     = 0;
  logic [DATA_W-1:0] bits        = '0;
  logic [DATA_W-1:0] exp_byte    = '0;

  always @(negedge m_clk) begin
    if (!n_reset) begin
      check("reset_lines", {spi_mosi_out, spi_sclk_out, spi_cs_n_out, busy}, 4'b0010);
      in_frame  = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (!spi_cs_n_out) begin
        if (!in_frame) begin
          in_frame    = 1'b1;
          nbits       = 0;
          low_cnt     = 0;
          bits        = '0;
          mosi_stable = 1'b1;
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_frame: cs_n fell at cycle %0d, required no frame", cyc);
            exp_byte = '0;
          end else begin
            exp_byte = exp_q.pop_front();
            check("launch_latency", cyc, exp_t_q.pop_front());
          end
        end
        low_cnt++;
        if (spi_sclk_out && !prev_sclk) begin
          bits      = {bits[DATA_W-2:0], spi_mosi_out};
          nbits++;
          rise_mosi = spi_mosi_out;
        end else if (spi_sclk_out && (spi_mosi_out !== rise_mosi)) begin
          mosi_stable = 1'b0;
        end
        check("busy_in_frame", busy, 1);
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          check("frame_data", bits, exp_byte);
          check("frame_sclk_rises", nbits, DATA_W);
          check("cs_low_cycles", low_cnt, FRAME_LOW);
          check("mosi_stable_sclk_high", mosi_stable, 1);
          check("done_lines", {spi_mosi_out, spi_sclk_out, busy}, 3'b001);
        end else begin
          check("idle_lines", {spi_mosi_out, spi_sclk_out, busy}, 3'b000);
        end
      end
      prev_sclk = spi_sclk_out;
    end
  end

  // Stimulus.
  initial begin
    // Reset held with data_av toggling, then released with data_av low.
    for (int i = 0; i < 6; i++) step(i[0], DATA_W'($urandom));
    step(1'b0, '0);
    reset_release();
    idle(4);

    // Single frame.
    step(1'b1, 8'hA5);
    idle(22);

    // Level held high while data_in moves: one frame carrying the first value.
    for (int i = 0; i < 15; i++) step(1'b1, DATA_W'(2 + i));
    idle(22);

    // Edge while busy is dropped; the next edge after idle is taken.
    step(1'b1, 8'hFF);
    idle(4);
    step(1'b1, 8'h00);
    idle(20);
    step(1'b1, 8'h3C);
    idle(22);

    // Back-to-back strobes with a 16-cycle period.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 15; i++) step(1'b1, DATA_W'($urandom));
      step(1'b0, DATA_W'($urandom));
    end
    idle(22);

    // Reset in the middle of a frame, then a fresh frame.
    step(1'b1, 8'hC3);
    idle(6);
    reset_assert();
    for (int i = 0; i < 4; i++) step(i[0], DATA_W'($urandom));
    step(1'b0, '0);
    reset_release();
    idle(2);
    step(1'b1, DATA_W'($urandom));
    idle(22);

    // data_av already high when reset is released counts as an edge.
    reset_assert();
    step(1'b1, 8'h5A);
    reset_release();
    idle(22);

    // Random strobe runs with random data and occasional resets.
    for (int r = 0; r < 120; r++) begin
      logic av;
      int   len;
      av  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) step(av, DATA_W'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        reset_assert();
        step(1'($urandom_range(0, 1)), DATA_W'($urandom));
        reset_release();
      end
    end
    idle(2);

    // Drain with a bounded wait.
    for (int i = 0; i < 200 && (exp_q.size() != 0 || in_frame); i++) step(1'b0, '0);
    check("queue_drained", exp_q.size(), 0);
    check("frame_closed", in_frame, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    mismatched++;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
